// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM state
// encoding and the parity check helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

    // ones is the XOR of all data bits and the received parity bit.
    function automatic logic parity_fail(input int mode, input logic ones);
        if (mode == PAR_EVEN)
            return ones;
        else if (mode == PAR_ODD)
            return ~ones;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial pin; resets to the
// idle-high line level so reset release never looks like a start edge.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: start-bit validation, LSB-first data capture,
// optional parity, 1-2 stop bits and a valid/ready output register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dataValue,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 tick;
    logic                 accept;
    logic                 stop_fe;
    logic                 last_stop;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dataValue),
        .q   (rx_s)
    );

    assign tick      = (cnt == CNT_LAST);
    assign accept    = data_valid & data_ready;
    assign stop_fe   = stop_bad | ~rx_s;
    assign last_stop = (state == S_STOP) && tick && (bit_idx == STOP_LAST);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (state == S_DATA && tick)
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            rx_prev    <= 1'b1;
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_prev <= rx_s;

            // A consumer handshake in the load cycle frees the register for the new word.
            if (last_stop) begin
                if (!data_valid || accept) begin
                    data       <= shreg;
                    parity_err <= par_bad;
                    frame_err  <= stop_fe;
                    data_valid <= 1'b1;
                    if (accept)
                        overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    // The edge cycle itself is count 0, so the timer starts at 1.
                    if (rx_prev && !rx_s) begin
                        state <= S_START;
                        cnt   <= CW'(1);
                    end
                end
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state    <= S_DATA;
                            cnt      <= '0;
                            bit_idx  <= '0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        cnt     <= '0;
                        par_bad <= parity_fail(PARITY, (^shreg) ^ rx_s);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        cnt      <= '0;
                        stop_bad <= stop_fe;
                        if (bit_idx == STOP_LAST)
                            state <= stop_fe ? S_WAIT_HIGH : S_IDLE;
                        else
                            bit_idx <= bit_idx + IW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line (break) must return high before a new start is armed.
                    if (rx_s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised successor to the fixed 8N1 UART receiver. Samples an asynchronous serial line and recovers frames with configurable bit period, data width, parity and stop-bit count. Rejects false start bits, flags parity, framing and overrun errors, and presents each word on a valid/ready handshake. It sits between the board serial pin and any byte consumer (command decoder, FIFO).

## Interface
- CLKS_PER_BIT, 104, clock cycles per bit (1 MHz clk / 9600 baud); legal range ≥ 4
- DATA_BITS, 8, data bits per frame; legal range 5..9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- dataValue  in  1  serial line; idles high; asynchronous to clk
- data  out  DATA_BITS  received word, LSB received first
- data_valid  out  1  word and error flags valid
- data_ready  in  1  consumer accepts the word when it is high with data_valid
- parity_err  out  1  parity mismatch on the held word; 0 when PARITY = 0
- frame_err  out  1  a stop bit was sampled low on the held word
- overrun  out  1  sticky; a frame completed while data_valid was high
- busy  out  1  FSM not in IDLE

## Operation
- dataValue passes through a 2-flop synchroniser; the FSM sees only the synchronised signal `rx_s`.
- FSM states and transitions:
  - IDLE → START when `rx_s` falls (registered previous value 1, current 0).
  - START: at count CLKS_PER_BIT/2 (integer division), if `rx_s` = 1 → IDLE (glitch, no output). Otherwise → DATA, and the bit counter clears.
  - DATA: sample every CLKS_PER_BIT cycles and shift in LSB first. After DATA_BITS samples → PARITY if PARITY ≠ 0, otherwise → STOP.
  - PARITY: one sample. Even parity: XOR of data and parity bit must be 0. Odd parity: it must be 1.
  - STOP: STOP_BITS samples, one CLKS_PER_BIT apart. If any sample is low, frame_err is set.
  - After the last stop sample: with no frame error → IDLE; with a frame error → WAIT_HIGH.
  - WAIT_HIGH → IDLE once `rx_s` = 1. No start detection in this state (break handling).
- Output register, loaded on the last stop sample:
  - If data_valid = 0: load data, parity_err and frame_err, then set data_valid.
  - If data_valid = 1 (and not being accepted that same cycle): drop the new frame, keep the held word, set overrun.
  - Handshake accepted in the same cycle as a load: the handshake completes and the new word loads, so no overrun.
- data_valid clears on the cycle after data_valid & data_ready. overrun clears on the same handshake.
- Bit counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_BITS+1).
- rst low at any time: all outputs go to 0 immediately and the FSM goes to IDLE; the synchroniser flops are set to 1. Any partial frame is discarded.

## Timing
- Reset values: data = 0, data_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
- Synchroniser latency: 2 cycles from pin to `rx_s`.
- Let E be the first cycle `rx_s` = 0. Then data_valid rises at E + CLKS_PER_BIT/2 + CLKS_PER_BIT·(DATA_BITS + (PARITY≠0) + STOP_BITS) + 1.
  - Example, 8N1 with CLKS_PER_BIT = 104: E + 989.
- busy rises the cycle after E. It falls the cycle the FSM re-enters IDLE.
- A new start edge is accepted from the first IDLE cycle, so back-to-back frames need no extra idle time.
- data_valid stays high for a single cycle when data_ready is tied high.

## Structure
- Shared package `uart_pkg`:
  - parity mode constants PAR_NONE / PAR_EVEN / PAR_ODD
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
- One sub-module, `uart_sync2`: the 2-flop synchroniser with asynchronous active-low reset, reset value 1.
- Bit timer, FSM, shift register and output register live in uart_rx_core.

## Test plan
- Back-to-back frames: 8N1, CLKS_PER_BIT = 104, data_ready = 1. Send 0x65 then 0xCF (bits 1,0,1,0,0,1,1,0 then 1,1,1,1,0,0,1,1). Required: two single-cycle data_valid pulses carrying 0x65 then 0xCF, all error flags 0, first pulse at E + 989.
- False start: line low for 30 cycles, then high. Required: busy pulses, FSM returns to IDLE, no data_valid.
- Parity error: PARITY = 1. Send 0xA5 with parity bit 1 (correct value is 0). Required: data = 0xA5, parity_err = 1, frame_err = 0.
  - Then send 0x3C with parity 0. Required: parity_err = 0.
- Break: line low for 2000 cycles, then high, then send 0x3C. Required: one word 0x00 with frame_err = 1, no further output while the line is low, then 0x3C received clean.
- Overrun: data_ready = 0, send 0x11 then 0x22. Required: data stays 0x11, overrun = 1. Then raise data_ready for 1 cycle. Required: data_valid = 0 and overrun = 0 the next cycle.
- Reset mid-frame: drive rst low during data bit 4 of 0x5A. Required: outputs go to 0 asynchronously, busy = 0. After release, the next 0x5A frame is received correctly with no errors.
